// File: rtl/xnorpop_pkg.sv
// xnorpop_pkg: shared states, default sizes and helpers for the xnor-popcount sequencer
package xnorpop_pkg;
    localparam int W_DEF          = 128;
    localparam int SUM_W_DEF      = 8;
    localparam int MAX_CHUNKS_DEF = 16;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/xnorpop_seq_ctrl_if.sv
// xnorpop_seq_ctrl_if: job, chunk, datapath and result signals of the xnor-popcount sequencer
interface xnorpop_seq_ctrl_if
    import xnorpop_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = clog2(MAX_CHUNKS_DEF) + 1,
    parameter int ACC_W = SUM_W_DEF + clog2(MAX_CHUNKS_DEF)
);
    logic             start;
    logic [CNT_W-1:0] num_chunks;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic [W-1:0]     pc_inx;
    logic [W-1:0]     pc_iny;
    logic [SUM_W-1:0] pc_sum;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_sum;
    logic             res_act;
    modport master (
        output start, num_chunks, in_valid, in_x, in_y, pc_sum, res_ready,
        input  busy, in_ready, pc_inx, pc_iny, res_valid, res_sum, res_act
    );
    modport slave (
        input  start, num_chunks, in_valid, in_x, in_y, pc_sum, res_ready,
        output busy, in_ready, pc_inx, pc_iny, res_valid, res_sum, res_act
    );
endinterface

// File: rtl/popcount_mimic_circuit.sv
// popcount_mimic_circuit: combinational popcount of xnor(inx, iny)
module popcount_mimic_circuit #(
    parameter int W     = 128,
    parameter int SUM_W = 8
) (
    input  logic [W-1:0]     inx,
    input  logic [W-1:0]     iny,
    output logic [SUM_W-1:0] sum
);
    // count bit positions where the operands agree
    always_comb begin
        sum = '0;
        for (int i = 0; i < W; i++) sum = sum + SUM_W'(inx[i] ~^ iny[i]);
    end
endmodule

// File: rtl/xnorpop_lat_pipe.sv
// xnorpop_lat_pipe: tags accepted chunks and strobes their retire LAT edges later
module xnorpop_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    output logic retire,
    output logic pending
);
    logic [LAT-1:0] pipe;
    // shift a tag in every edge; a 1 marks a chunk whose sum is still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else pipe <= LAT'({pipe, push});
    end
    assign retire  = pipe[LAT-1];
    assign pending = |pipe;
endmodule

// File: rtl/xnorpop_seq_ctrl.sv
// xnorpop_seq_ctrl: streams chunk pairs through the xnor-popcount datapath and accumulates the total
module xnorpop_seq_ctrl
    import xnorpop_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int MAX_CHUNKS = MAX_CHUNKS_DEF,
    parameter int PC_LAT     = 1,
    parameter int SUM_W      = clog2(W) + 1,
    parameter int CNT_W      = clog2(MAX_CHUNKS) + 1,
    parameter int ACC_W      = SUM_W + clog2(MAX_CHUNKS)
) (
    input logic               clk,
    input logic               rst_n,
    xnorpop_seq_ctrl_if.slave bus
);
    state_t           state;
    logic [CNT_W-1:0] n, acc_cnt, ret_cnt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             accept, retire, pending, last_acc, last_ret, finish;

    function automatic logic sign_act(input logic [ACC_W-1:0] a, input logic [CNT_W-1:0] k);
        return {a, 1'b0} >= (ACC_W+1)'(k) * (ACC_W+1)'(W);
    endfunction

    assign accept       = (state == STREAM) && bus.in_valid;
    assign acc_nxt      = acc + (retire ? ACC_W'(bus.pc_sum) : '0);
    assign last_acc     = accept && (acc_cnt == n - 1'b1);
    assign last_ret     = retire && (ret_cnt == n - 1'b1);
    assign finish       = (state == STREAM && last_acc && last_ret) ||
                          (state == DRAIN && (last_ret || !pending));
    assign bus.in_ready = (state == STREAM);
    assign bus.busy     = (state != IDLE);

    xnorpop_lat_pipe #(.LAT(PC_LAT)) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (accept),
        .retire (retire),
        .pending(pending)
    );

    // job FSM: launch accepted chunks, fold retired sums, present and hold the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            n             <= '0;
            acc           <= '0;
            acc_cnt       <= '0;
            ret_cnt       <= '0;
            bus.pc_inx    <= '0;
            bus.pc_iny    <= '0;
            bus.res_valid <= 1'b0;
            bus.res_sum   <= '0;
            bus.res_act   <= 1'b0;
        end else begin
            if (accept) begin
                bus.pc_inx <= bus.in_x;
                bus.pc_iny <= bus.in_y;
                acc_cnt    <= acc_cnt + 1'b1;
            end
            if (retire) begin
                acc     <= acc_nxt;
                ret_cnt <= ret_cnt + 1'b1;
            end
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.num_chunks == '0) begin
                        state         <= DONE;
                        bus.res_valid <= 1'b1;
                        bus.res_sum   <= '0;
                        bus.res_act   <= 1'b1;
                    end else begin
                        state   <= STREAM;
                        n       <= (bus.num_chunks > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS) : bus.num_chunks;
                        acc     <= '0;
                        acc_cnt <= '0;
                        ret_cnt <= '0;
                    end
                end
                STREAM: if (last_acc) state <= DRAIN;
                DRAIN: ;
                DONE: if (bus.res_ready) begin
                    state         <= IDLE;
                    bus.res_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (finish) begin
                state         <= DONE;
                bus.res_valid <= 1'b1;
                bus.res_sum   <= acc_nxt;
                bus.res_act   <= sign_act(acc_nxt, n);
            end
        end
    end
endmodule

// File: tb/tb_xnorpop_seq_ctrl.sv
// tb_xnorpop_seq_ctrl: scoreboard bench driving a PC_LAT=1 and a PC_LAT=3 sequencer with identical jobs
module tb_xnorpop_seq_ctrl;
    localparam int W = 128, SUM_W = 8, CNT_W = 5, ACC_W = 12, MAXC = 16;
    typedef struct {
        logic [ACC_W-1:0] sum;
        logic             act;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b1;
    int n_chk = 0, n_pass = 0, cyc = 0;
    int acc1 = 0, acc3 = 0, rdy1 = 0, rise1 = 0, rise3 = 0;
    logic v1_q = 1'b0, v3_q = 1'b0;
    exp_t q1[$], q3[$];
    logic [SUM_W-1:0] raw3, d3a, d3b;

    xnorpop_seq_ctrl_if #(.W(W), .SUM_W(SUM_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) b1 ();
    xnorpop_seq_ctrl_if #(.W(W), .SUM_W(SUM_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) b3 ();

    always #5 clk = ~clk;

    assign b3.start      = b1.start;
    assign b3.num_chunks = b1.num_chunks;
    assign b3.in_valid   = b1.in_valid;
    assign b3.in_x       = b1.in_x;
    assign b3.in_y       = b1.in_y;
    assign b3.res_ready  = b1.res_ready;

    xnorpop_seq_ctrl #(.W(W), .MAX_CHUNKS(MAXC), .PC_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    xnorpop_seq_ctrl #(.W(W), .MAX_CHUNKS(MAXC), .PC_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    popcount_mimic_circuit #(.W(W), .SUM_W(SUM_W)) u_dp1 (.inx(b1.pc_inx), .iny(b1.pc_iny), .sum(b1.pc_sum));
    popcount_mimic_circuit #(.W(W), .SUM_W(SUM_W)) u_dp3 (.inx(b3.pc_inx), .iny(b3.pc_iny), .sum(raw3));

    // two extra datapath stages so the second sequencer sees a 3-edge latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d3a <= '0;
            d3b <= '0;
        end else begin
            d3a <= raw3;
            d3b <= d3a;
        end
    end
    assign b3.pc_sum = d3b;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_w();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(posedge clk) cyc++;

    // activity counters and result rise timestamps
    always @(negedge clk) begin
        if (b1.in_valid && b1.in_ready) acc1++;
        if (b3.in_valid && b3.in_ready) acc3++;
        if (b1.in_ready) rdy1++;
        if (b1.res_valid && !v1_q) rise1 = cyc;
        if (b3.res_valid && !v3_q) rise3 = cyc;
        v1_q = b1.res_valid;
        v3_q = b3.res_valid;
    end

    // scoreboard: every result handshake must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (b1.res_valid && b1.res_ready) begin
            chk("res1_expected", W'(q1.size() != 0), W'(1));
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("res1_sum", W'(b1.res_sum), W'(e.sum));
                chk("res1_act", W'(b1.res_act), W'(e.act));
            end
        end
        if (b3.res_valid && b3.res_ready) begin
            chk("res3_expected", W'(q3.size() != 0), W'(1));
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("res3_sum", W'(b3.res_sum), W'(e.sum));
                chk("res3_act", W'(b3.res_act), W'(e.act));
            end
        end
    end

    task automatic push_exp(input int sum, input int eff);
        exp_t e;
        e.sum = ACC_W'(sum);
        e.act = (2 * sum >= eff * W);
        q1.push_back(e);
        q3.push_back(e);
    endtask

    task automatic start_job(input int n);
        acc1 = 0;
        acc3 = 0;
        rdy1 = 0;
        b1.num_chunks = CNT_W'(n);
        b1.start = 1'b1;
        step();
        b1.start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        b1.in_valid = 1'b1;
        b1.in_x = x;
        b1.in_y = y;
        for (int t = 0; t < 50 && !b1.in_ready; t++) step();
        chk("in_ready_seen", W'(b1.in_ready), W'(1));
        step();
        b1.in_valid = 1'b0;
        chk("pc1_inx_load", b1.pc_inx, x);
        chk("pc1_iny_load", b1.pc_iny, y);
        chk("pc3_inx_load", b3.pc_inx, x);
    endtask

    task automatic wait_res();
        for (int t = 0; t < 200 && (q1.size() != 0 || q3.size() != 0); t++) step();
        chk("result_drain", W'(q1.size() + q3.size()), W'(0));
        step();
    endtask

    task automatic run_job(input int n, input int gap, input bit rnd, input logic [W-1:0] fx, input logic [W-1:0] fy);
        logic [W-1:0] xs [MAXC];
        logic [W-1:0] ys [MAXC];
        int eff, sum;
        eff = (n > MAXC) ? MAXC : n;
        sum = 0;
        for (int i = 0; i < eff; i++) begin
            xs[i] = rnd ? rand_w() : fx;
            ys[i] = !rnd ? fy : ($urandom_range(0, 1) != 0) ? rand_w() : xs[i] ^ (rand_w() & rand_w());
            sum += $countones(~(xs[i] ^ ys[i]));
        end
        push_exp(sum, eff);
        start_job(n);
        for (int i = 0; i < eff; i++) begin
            if (i > 0) repeat (gap) begin
                step();
                chk("pc1_inx_hold", b1.pc_inx, xs[i-1]);
                chk("pc1_iny_hold", b1.pc_iny, ys[i-1]);
            end
            send(xs[i], ys[i]);
        end
        wait_res();
        chk("accepts1", W'(acc1), W'(eff));
        chk("accepts3", W'(acc3), W'(eff));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, W'(b1.busy), W'(0));
        chk({tag, "_in_ready"}, W'(b1.in_ready), W'(0));
        chk({tag, "_res_valid"}, W'(b1.res_valid), W'(0));
        chk({tag, "_res_act"}, W'(b1.res_act), W'(0));
        chk({tag, "_res_sum"}, W'(b1.res_sum), W'(0));
        chk({tag, "_pc_inx"}, b1.pc_inx, W'(0));
        chk({tag, "_pc_iny"}, b1.pc_iny, W'(0));
        chk({tag, "_busy3"}, W'(b3.busy), W'(0));
        chk({tag, "_pc3_inx"}, b3.pc_inx, W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        b1.start = 1'b0;
        b1.num_chunks = '0;
        b1.in_valid = 1'b0;
        b1.in_x = '0;
        b1.in_y = '0;
        b1.res_ready = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        chk_cleared("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        // one chunk, no matching bits, latency against accept edge
        push_exp(0, 1);
        start_job(1);
        send('0, '1);
        chk("t1_valid1_early", W'(b1.res_valid), W'(0));
        step();
        chk("t1_valid1_on_time", W'(b1.res_valid), W'(1));
        chk("t1_valid3_early", W'(b3.res_valid), W'(0));
        step();
        step();
        chk("t1_valid3_on_time", W'(b3.res_valid), W'(1));
        wait_res();
        chk("t1_lat_shift", W'(rise3 - rise1), W'(2));
        // back-to-back all-matching chunks
        run_job(4, 0, 1'b0, '0, '0);
        chk("t2_ready_cycles", W'(rdy1), W'(4));
        // gapped chunks, 96 matching bits each
        run_job(2, 3, 1'b0, '0, {32{4'h1}});
        // empty job with result held under backpressure, start pulses ignored
        push_exp(0, 0);
        b1.res_ready = 1'b0;
        start_job(0);
        chk("t4_valid1", W'(b1.res_valid), W'(1));
        chk("t4_valid3", W'(b3.res_valid), W'(1));
        repeat (3) begin
            b1.start = 1'b1;
            b1.num_chunks = CNT_W'(3);
            step();
            chk("t4_hold_valid", W'(b1.res_valid), W'(1));
            chk("t4_hold_sum", W'(b1.res_sum), W'(0));
            chk("t4_hold_act", W'(b1.res_act), W'(1));
            chk("t4_hold_busy", W'(b1.busy), W'(1));
        end
        b1.start = 1'b0;
        b1.res_ready = 1'b1;
        wait_res();
        chk("t4_idle", W'(b1.busy), W'(0));
        chk("t4_no_accepts", W'(acc1), W'(0));
        // oversize job clamps to sixteen chunks
        run_job(20, 0, 1'b1, '0, '0);
        chk("t5_lat_shift", W'(rise3 - rise1), W'(2));
        for (int k = 0; k < 4; k++) run_job($urandom_range(1, MAXC), $urandom_range(0, 2), 1'b1, '0, '0);
        // abort mid-stream, then a fresh job
        start_job(4);
        send(rand_w(), rand_w());
        send(rand_w(), rand_w());
        rst_n = 1'b0;
        #1;
        chk_cleared("abort");
        step();
        rst_n = 1'b1;
        step();
        run_job(1, 0, 1'b1, '0, '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
